// File: rtl/neander_pkg.sv
// Shared types and default sizes for the Neander-X external memory responder.
package neander_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned RAM_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } ram_resp_state_t;

endpackage

// File: rtl/neander_ram_array.sv
// 2**ADDR_W x DATA_W RAM: async-reset clear, one synchronous write port, one async read port.
module neander_ram_array #(
    parameter int unsigned ADDR_W = neander_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = neander_pkg::DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/neander_ext_ram_responder.sv
// Board-side slave for the Neander-X memory pins: RAM, I/O output latch, and host load port
// that fills the RAM while the CPU is held in reset.
module neander_ext_ram_responder
    import neander_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_we,
    input  logic              ram_oe,
    input  logic              io_wr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic [DATA_W-1:0] cpu_data_oe,
    output logic [DATA_W-1:0] ram_data,
    output logic              cpu_rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              ld_restart,
    output logic [DATA_W-1:0] io_latch,
    output logic [7:0]        io_count,
    output logic              bus_err
);

    ram_resp_state_t   state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              io_wr_q;
    logic [DATA_W-1:0] io_latch_q, io_latch_d;
    logic [7:0]        io_count_q, io_count_d;
    logic              bus_err_q, bus_err_d;

    logic              run;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    neander_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (reset),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (ram_addr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        run         = (state_q == ST_RUN);
        state_d     = state_q;
        ptr_d       = ptr_q;
        cpu_rst_n_d = 1'b0;
        io_latch_d  = io_latch_q;
        io_count_d  = io_count_q;
        bus_err_d   = bus_err_q;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = ld_data;
        ld_ready    = 1'b0;
        ram_data    = '0;

        case (state_q)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we = 1'b1;
                    if (ld_last) begin
                        state_d = ST_RUN;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                cpu_rst_n_d = 1'b1;
                mem_we      = ram_we;
                mem_waddr   = ram_addr;
                mem_wdata   = cpu_data;
                if (ram_oe && !ram_we) begin
                    ram_data = mem_rdata;
                end
                if (io_wr && !io_wr_q) begin
                    io_latch_d = cpu_data;
                    io_count_d = io_count_q + 8'd1;
                end
                if (ram_we && (ram_oe || (cpu_data_oe != '1) || io_wr)) begin
                    bus_err_d = 1'b1;
                end
                // A write in the final RUN cycle still lands; restart only redirects the next state.
                if (ld_restart) begin
                    state_d     = ST_LOAD;
                    ptr_d       = '0;
                    cpu_rst_n_d = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            ptr_q       <= '0;
            cpu_rst_n_q <= 1'b0;
            io_wr_q     <= 1'b0;
            io_latch_q  <= '0;
            io_count_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            io_wr_q     <= io_wr;
            io_latch_q  <= io_latch_d;
            io_count_q  <= io_count_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign io_latch  = io_latch_q;
    assign io_count  = io_count_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_neander_ext_ram_responder.sv
// Directed and randomized bench for neander_ext_ram_responder against a cycle-level behavioural model.
module tb_neander_ext_ram_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ram_addr;
    logic       ram_we, ram_oe, io_wr;
    logic [7:0] cpu_data, cpu_data_oe;
    logic [7:0] ram_data;
    logic       cpu_rst_n;
    logic       ld_valid, ld_ready, ld_last, ld_restart;
    logic [7:0] ld_data;
    logic [7:0] io_latch, io_count;
    logic       bus_err;

    always #5 clk = ~clk;

    neander_ext_ram_responder #(
        .ADDR_W (5),
        .DATA_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe),
        .io_wr       (io_wr),
        .cpu_data    (cpu_data),
        .cpu_data_oe (cpu_data_oe),
        .ram_data    (ram_data),
        .cpu_rst_n   (cpu_rst_n),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_restart  (ld_restart),
        .io_latch    (io_latch),
        .io_count    (io_count),
        .bus_err     (bus_err)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: memory image, mode, pointer, I/O latch/counter, sticky error.
    logic [7:0] m_mem [32];
    bit         m_run;
    bit         m_rstn;
    int         m_ptr;
    logic [7:0] m_latch;
    logic [7:0] m_count;
    bit         m_err;
    bit         m_prev_io;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
        m_run = 0; m_rstn = 0; m_ptr = 0;
        m_latch = 8'h00; m_count = 8'h00; m_err = 0; m_prev_io = 0;
    endtask

    task automatic model_edge();
        if (m_run) begin
            if (ram_we) m_mem[ram_addr] = cpu_data;
            if (io_wr && !m_prev_io) begin
                m_latch = cpu_data;
                m_count = m_count + 8'd1;
            end
            if (ram_we && (ram_oe || cpu_data_oe != 8'hFF || io_wr)) m_err = 1;
            if (ld_restart) begin
                m_run = 0; m_rstn = 0; m_ptr = 0;
            end else begin
                m_rstn = 1;
            end
        end else begin
            m_rstn = 0;
            if (ld_valid) begin
                m_mem[m_ptr] = ld_data;
                if (ld_last) begin
                    m_run = 1; m_ptr = 0;
                end else begin
                    m_ptr = (m_ptr + 1) % 32;
                end
            end
        end
        m_prev_io = io_wr;
    endtask

    task automatic check_outputs();
        logic [7:0] exp_rd;
        exp_rd = (m_run && ram_oe && !ram_we) ? m_mem[ram_addr] : 8'h00;
        check("ram_data", ram_data, exp_rd);
        check("ld_ready", ld_ready, !m_run);
        check("cpu_rst_n", cpu_rst_n, m_rstn);
        check("io_latch", io_latch, m_latch);
        check("io_count", io_count, m_count);
        check("bus_err", bus_err, m_err);
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        ram_addr = '0; ram_we = 0; ram_oe = 0; io_wr = 0;
        cpu_data = '0; cpu_data_oe = '0;
        ld_valid = 0; ld_data = '0; ld_last = 0; ld_restart = 0;
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d, input bit last);
        ld_valid = 1; ld_data = d; ld_last = last;
        step();
        ld_valid = 0; ld_last = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        apply_reset();

        // Initial load of three bytes; ready drops on entry to RUN, CPU released one cycle later.
        load_byte(8'h20, 0);
        load_byte(8'h1E, 0);
        load_byte(8'hF0, 1);
        #1 check("ld_ready_drop", ld_ready, 1'b0);
        check("rstn_still_low", cpu_rst_n, 1'b0);
        step();
        #1 check("rstn_rise", cpu_rst_n, 1'b1);

        ram_addr = 5'd1; ram_oe = 1;
        #1 check("read_addr1", ram_data, 8'h1E);
        step();
        ram_oe = 0;
        #1 check("read_oe_off", ram_data, 8'h00);
        step();

        ram_we = 1; ram_addr = 5'h1F; cpu_data = 8'hA5; cpu_data_oe = 8'hFF;
        step();
        ram_we = 0; ram_oe = 1; cpu_data_oe = 8'h00;
        #1 check("raw_1f", ram_data, 8'hA5);
        check("no_err", bus_err, 1'b0);
        step();
        ram_oe = 0;

        io_wr = 1; cpu_data = 8'h42;
        repeat (3) step();
        io_wr = 0; step();
        io_wr = 1; cpu_data = 8'h07; step();
        io_wr = 0; step();
        #1 check("io_latch_07", io_latch, 8'h07);
        check("io_count_2", io_count, 8'd2);

        ram_we = 1; ram_oe = 1; cpu_data_oe = 8'hFF; ram_addr = 5'd2; cpu_data = 8'h11;
        #1 check("we_oe_rd_zero", ram_data, 8'h00);
        step();
        ram_we = 0; ram_oe = 0;
        #1 check("err_set", bus_err, 1'b1);
        step(); step();
        ld_restart = 1; step();
        ld_restart = 0;
        #1 check("restart_rstn", cpu_rst_n, 1'b0);
        check("restart_ready", ld_ready, 1'b1);
        check("err_sticky", bus_err, 1'b1);

        // 33-byte load wraps the pointer and overwrites address 0.
        for (int i = 0; i <= 32; i++) load_byte(8'(i), i == 32);
        ram_oe = 1; ram_addr = 5'd0;
        #1 check("wrap_mem0", ram_data, 8'd32);
        step();
        ram_addr = 5'd1;
        #1 check("wrap_mem1", ram_data, 8'd1);
        step();
        ram_oe = 0;

        // Reset mid-load discards everything; reload one zero byte and scan all addresses.
        ld_restart = 1; step(); ld_restart = 0;
        load_byte(8'hCC, 0);
        load_byte(8'hDD, 0);
        ld_valid = 1; ld_data = 8'hEE;
        apply_reset();
        idle();
        load_byte(8'h00, 1);
        step();
        ram_oe = 1;
        for (int a = 0; a < 32; a++) begin
            ram_addr = 5'(a);
            #1 check("post_reset_zero", ram_data, 8'h00);
            step();
        end
        idle();

        // Randomized traffic across load, run, restart and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
            end
            ram_addr    = 5'($urandom_range(0, 31));
            ram_we      = ($urandom_range(0, 3) == 0);
            ram_oe      = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) io_wr = ~io_wr;
            cpu_data    = 8'($urandom);
            cpu_data_oe = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
            ld_valid    = ($urandom_range(0, 1) == 1);
            ld_data     = 8'($urandom);
            ld_last     = ($urandom_range(0, 7) == 0);
            ld_restart  = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
